// File: rtl/spi_pkg.sv
// Shared types for the SPI controller: FSM state encoding and bus-mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    NEXT  = 3'd3,
    TRAIL = 3'd4,
    GUARD = 3'd5
  } spi_state_t;

  // Only mode 0 is implemented; these pin the bus mode for future variants.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: pulses every CLK_DIV cycles, restarting from zero on clear.
// Tick is combinational from the counter, so it may feed next-state logic that drives clr_i.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_main.sv
// Mode-0 MSB-first SPI controller with word-level valid/ready; ssn stays low across burst words.
// One word costs LEAD + 2*WORD_WIDTH + TRAIL half-periods; tx_ready is high only in IDLE and NEXT.
module spi_main
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  ssn,
  output logic                  mosi,
  input  logic                  miso
);

  if (WORD_WIDTH < 2) begin : g_bad_width
    $error("spi_main: WORD_WIDTH must be >= 2");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_main: CLK_DIV must be >= 1");
  end

  localparam int BW = $clog2(WORD_WIDTH);

  spi_state_t            state_q, state_d;
  logic                  ssn_q, ssn_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                  tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic                  last_q, last_d;
  logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tick, tick_clr, accept;

  assign accept = tx_valid && tx_ready_q;

  always_comb begin
    state_d    = state_q;
    ssn_d      = ssn_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    bit_d      = bit_q;
    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          tx_sr_d = tx_data;
          last_d  = tx_last;
          mosi_d  = tx_data[WORD_WIDTH-1];
          ssn_d   = 1'b0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[WORD_WIDTH-2:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BW'(WORD_WIDTH - 1)) begin
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
              state_d    = last_q ? TRAIL : NEXT;
            end else begin
              tx_sr_d = {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
              mosi_d  = tx_sr_q[WORD_WIDTH-2];
              bit_d   = bit_q + 1'b1;
            end
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          ssn_d   = 1'b1;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered so it tracks the state it describes from the cycle of entry.
  assign tx_ready_d = (state_d == IDLE) || (state_d == NEXT);
  assign tick_clr   = (state_d != state_q) || (state_q == IDLE) || (state_q == NEXT);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ssn_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      last_q     <= 1'b0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      ssn_q      <= ssn_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      last_q     <= last_d;
      bit_q      <= bit_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign ssn      = ssn_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_main.sv
// Bench for spi_main: 8-bit/CLK_DIV=2 instance with selectable miso source and a 16-bit/CLK_DIV=1 loopback instance.
module tb_spi_main;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- 8-bit instance ----------------
  logic [7:0] tx_data8 = '0, rx_data8;
  logic       tx_last8 = 1'b0, tx_valid8 = 1'b0;
  logic       tx_ready8, rx_valid8, busy8, sclk8, ssn8, mosi8, miso8;
  logic [1:0] miso_mode = 2'd0; // 0 loopback, 1 held high, 2 held low, 3 subordinate model (miso low)

  assign miso8 = (miso_mode == 2'd0) ? mosi8 : (miso_mode == 2'd1);

  spi_main #(.WORD_WIDTH(8), .CLK_DIV(2)) u_dut8 (
    .clk(clk), .rstn(rstn), .tx_data(tx_data8), .tx_last(tx_last8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8),
    .sclk(sclk8), .ssn(ssn8), .mosi(mosi8), .miso(miso8)
  );

  // ---------------- 16-bit instance ----------------
  logic [15:0] tx_data16 = '0, rx_data16;
  logic        tx_last16 = 1'b0, tx_valid16 = 1'b0;
  logic        tx_ready16, rx_valid16, busy16, sclk16, ssn16, mosi16;

  spi_main #(.WORD_WIDTH(16), .CLK_DIV(1)) u_dut16 (
    .clk(clk), .rstn(rstn), .tx_data(tx_data16), .tx_last(tx_last16), .tx_valid(tx_valid16),
    .tx_ready(tx_ready16), .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16),
    .sclk(sclk16), .ssn(ssn16), .mosi(mosi16), .miso(mosi16)
  );

  // ---------------- scoreboards and monitors ----------------
  logic [7:0]  exp8_q[$];
  logic [7:0]  exp_sub_q[$];
  logic [15:0] exp16_q[$];

  int rx_pulses8 = 0, ssn_low8 = 0, ssn_rise8 = 0, gap8 = 0, mosi_hi8 = 0, rise8 = 0;
  int rx_pulses16 = 0;
  logic ssn_prev8 = 1'b1, sclk_prev8 = 1'b0, mosi_prev8 = 1'b0;
  logic [7:0] e8, sub_sr, es;
  logic [15:0] e16;
  int sub_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid8) begin
      rx_pulses8++;
      vectors++;
      if (exp8_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx8_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data8);
      end else begin
        e8 = exp8_q.pop_front();
        if (rx_data8 !== e8) begin
          miscompares++;
          $display("FAIL rx8_data: got %h, required %h", rx_data8, e8);
        end
      end
    end
    if (!ssn8) ssn_low8++;
    if (ssn8 && !ssn_prev8) ssn_rise8++;
    if (tx_ready8 && !ssn8) gap8++;
    if (!ssn8 && mosi8) mosi_hi8++;
    if (ssn8) sub_cnt = 0;
    if (sclk8 && !sclk_prev8) begin
      rise8++;
      vectors++;
      if (mosi8 !== mosi_prev8) begin
        miscompares++;
        $display("FAIL mosi_stable: mosi %b at sclk rise, was %b before it", mosi8, mosi_prev8);
      end
      if (miso_mode == 2'd3 && !ssn8) begin
        sub_sr = {sub_sr[6:0], mosi8};
        sub_cnt++;
        if (sub_cnt == 8) begin
          sub_cnt = 0;
          vectors++;
          if (exp_sub_q.size() == 0) begin
            miscompares++;
            $display("FAIL sub_unexpected: subordinate got %h, required nothing", sub_sr);
          end else begin
            es = exp_sub_q.pop_front();
            if (sub_sr !== es) begin
              miscompares++;
              $display("FAIL sub_data: subordinate got %h, required %h", sub_sr, es);
            end
          end
        end
      end
    end
    ssn_prev8  = ssn8;
    sclk_prev8 = sclk8;
    mosi_prev8 = mosi8;
  end

  always @(negedge clk) begin
    if (rx_valid16) begin
      rx_pulses16++;
      vectors++;
      if (exp16_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx16_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data16);
      end else begin
        e16 = exp16_q.pop_front();
        if (rx_data16 !== e16) begin
          miscompares++;
          $display("FAIL rx16_data: got %h, required %h", rx_data16, e16);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] rx_expect8(input logic [7:0] d);
    case (miso_mode)
      2'd0:    return d;
      2'd1:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic send8(input logic [7:0] d, input logic last, input bit push);
    int n = 0;
    @(negedge clk);
    tx_data8 = d; tx_last8 = last; tx_valid8 = 1'b1;
    if (push) begin
      exp8_q.push_back(rx_expect8(d));
      if (miso_mode == 2'd3) exp_sub_q.push_back(d);
    end
    while (!tx_ready8 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      vectors++; miscompares++;
      $display("FAIL send8_timeout: tx_ready stayed %b, required 1", tx_ready8);
    end
    @(negedge clk);
    tx_valid8 = 1'b0;
  endtask

  task automatic wait_idle8(input string tag);
    int n = 0;
    while ((busy8 || !tx_ready8) && n < 500) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 500) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b tx_ready=%b, required 0/1", tag, busy8, tx_ready8);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (exp8_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_rx: %0d words outstanding, required 0", tag, exp8_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sclk8, ssn8, mosi8, tx_ready8, rx_valid8, busy8} !== 6'b010000 || rx_data8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: sclk,ssn,mosi,rdy,rxv,busy=%b rx=%h, required 010000 rx=00",
               {sclk8, ssn8, mosi8, tx_ready8, rx_valid8, busy8}, rx_data8);
    end
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_ready8 !== 1'b1 || tx_ready16 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: tx_ready=%b/%b, required 1/1", tx_ready8, tx_ready16);
    end
  endtask

  task automatic test_loopback;
    int s0, r0, p0, n;
    miso_mode = 2'd0;
    s0 = ssn_low8; r0 = rise8; p0 = rx_pulses8;
    send8(8'hA5, 1'b1, 1'b1);
    n = 0;
    while (!ssn8 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_ready8 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL ready_after_ssn: %0d cycles, required 2", n);
    end
    wait_idle8("loopback");
    vectors++;
    if (ssn_low8 - s0 != 36) begin
      miscompares++;
      $display("FAIL ssn_low_len: %0d cycles, required 36", ssn_low8 - s0);
    end
    vectors++;
    if (rise8 - r0 != 8) begin
      miscompares++;
      $display("FAIL sclk_rises: %0d, required 8", rise8 - r0);
    end
    vectors++;
    if (rx_pulses8 - p0 != 1) begin
      miscompares++;
      $display("FAIL loopback_pulses: %0d, required 1", rx_pulses8 - p0);
    end
  endtask

  task automatic test_const;
    int m0;
    miso_mode = 2'd1;
    m0 = mosi_hi8;
    send8(8'h00, 1'b1, 1'b1);
    wait_idle8("miso_high");
    vectors++;
    if (mosi_hi8 != m0) begin
      miscompares++;
      $display("FAIL mosi_zero: mosi high %0d cycles while selected, required 0", mosi_hi8 - m0);
    end
    miso_mode = 2'd2;
    send8(8'hFF, 1'b1, 1'b1);
    wait_idle8("miso_low");
  endtask

  task automatic test_burst;
    int g0, sr0, p0, n, bad;
    miso_mode = 2'd0;
    g0 = gap8; sr0 = ssn_rise8; p0 = rx_pulses8;
    send8(8'h12, 1'b0, 1'b1);
    n = 0;
    while (!tx_ready8 && n < 200) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ssn8 !== 1'b0 || tx_ready8 !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL burst_gap: %0d gap cycles with ssn high or ready low, required 0", bad);
    end
    send8(8'h34, 1'b1, 1'b1);
    wait_idle8("burst");
    vectors++;
    if (gap8 - g0 != 22) begin
      miscompares++;
      $display("FAIL burst_ready_cycles: ready with ssn low %0d cycles, required 22", gap8 - g0);
    end
    vectors++;
    if (ssn_rise8 - sr0 != 1) begin
      miscompares++;
      $display("FAIL burst_ssn_rises: %0d, required 1", ssn_rise8 - sr0);
    end
    vectors++;
    if (rx_pulses8 - p0 != 2) begin
      miscompares++;
      $display("FAIL burst_pulses: %0d, required 2", rx_pulses8 - p0);
    end
  endtask

  task automatic test_back_to_back;
    int sr0;
    miso_mode = 2'd3;
    sr0 = ssn_rise8;
    send8(8'h3C, 1'b0, 1'b1);
    send8(8'hC3, 1'b1, 1'b1);
    wait_idle8("b2b");
    vectors++;
    if (exp_sub_q.size() != 0 || ssn_rise8 - sr0 != 1) begin
      miscompares++;
      $display("FAIL b2b_sub: %0d words undelivered, %0d ssn rises, required 0 and 1",
               exp_sub_q.size(), ssn_rise8 - sr0);
    end
  endtask

  task automatic test_reset_mid;
    int r0, p0, n;
    miso_mode = 2'd0;
    r0 = rise8; p0 = rx_pulses8;
    send8(8'h5A, 1'b1, 1'b0);
    n = 0;
    while (rise8 - r0 < 5 && n < 200) begin @(negedge clk); n++; end
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if (ssn8 !== 1'b1 || sclk8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: ssn=%b sclk=%b busy=%b, required 1 0 0", ssn8, sclk8, busy8);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (rx_pulses8 != p0 || rx_data8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_rx: %0d pulses rx=%h, required 0 pulses rx=00", rx_pulses8 - p0, rx_data8);
    end
    send8(8'h5A, 1'b1, 1'b1);
    wait_idle8("after_reset");
  endtask

  task automatic test_wide;
    int n, p0;
    bit seen0;
    p0 = rx_pulses16;
    @(negedge clk);
    tx_data16 = 16'hBEEF; tx_last16 = 1'b1; tx_valid16 = 1'b1;
    exp16_q.push_back(16'hBEEF);
    n = 0;
    while (!tx_ready16 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    tx_valid16 = 1'b0;
    n = 0;
    while (!sclk16 && n < 20) begin @(negedge clk); n++; end
    n = 0; seen0 = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (!sclk16) seen0 = 1'b1;
      else if (seen0) break;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL wide_sclk_period: %0d cycles, required 2", n);
    end
    n = 0;
    while ((busy16 || !tx_ready16) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    vectors++;
    if (rx_pulses16 - p0 != 1 || exp16_q.size() != 0) begin
      miscompares++;
      $display("FAIL wide_pulses: %0d pulses %0d outstanding, required 1 and 0",
               rx_pulses16 - p0, exp16_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_const;
    test_burst;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
